sr_skew: RTL

SR_SKEW -- requirements
Module: sr_skew

---
 rtl/sr_skew.sv | 91 +++++++++
 1 files changed

// File: rtl/sr_skew.sv
// sr_skew: per-lane skew/deskew delay line with valid tracking and optional in-flight counter
//
// Parameters
//   CHANNELS    number of independent lanes
//   DAT_WIDTH   data bits per lane
//   BASE_DEPTH  delay of the least-delayed lane, in enabled cycles
//   STEP        delay increment between adjacent lanes
//   REVERSE     0 = lane 0 shortest (skew), 1 = lane CHANNELS-1 shortest (deskew)
//
// Ports
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset, clears valid stages and counter
//   i_en        global advance enable, 0 holds every stage and drops the inputs
//   i_dat_vld   per-lane input valid
//   i_dat       per-lane input data, lane c at [c*DAT_WIDTH +: DAT_WIDTH]
//   o_dat_vld   per-lane output valid, straight from the last stage
//   o_dat       per-lane output data, meaningful only while o_dat_vld is set
//   o_inflight  number of valid tokens currently held in all lanes
//
// Configuration
//   SR_SKEW_INFLIGHT_EN  builds the in-flight counter; otherwise o_inflight is tied to 0
module sr_skew #(
    parameter int CHANNELS   = 4,
    parameter int DAT_WIDTH  = 16,
    parameter int BASE_DEPTH = 1,
    parameter int STEP       = 1,
    parameter int REVERSE    = 0,
    localparam int MAX_D     = BASE_DEPTH + STEP * (CHANNELS - 1),
    localparam int CNT_W     = $clog2(CHANNELS * MAX_D + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_en,
    input  logic [CHANNELS-1:0]           i_dat_vld,
    input  logic [CHANNELS*DAT_WIDTH-1:0] i_dat,
    output logic [CHANNELS-1:0]           o_dat_vld,
    output logic [CHANNELS*DAT_WIDTH-1:0] o_dat,
    output logic [CNT_W-1:0]              o_inflight
);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        localparam int D = REVERSE != 0 ? BASE_DEPTH + STEP * (CHANNELS - 1 - c)
                                        : BASE_DEPTH + STEP * c;
        logic [D-1:0]         vld_q;
        logic [DAT_WIDTH-1:0] dat_q [D];
        always_ff @(posedge clk) begin
            if (!rst_n)
                vld_q <= '0;
            else if (i_en) begin
                vld_q[0] <= i_dat_vld[c];
                for (int s = 1; s < D; s++)
                    vld_q[s] <= vld_q[s-1];
            end
        end
        // data stages carry no reset; their content only matters beside a set valid
        always_ff @(posedge clk) begin
            if (i_en) begin
                dat_q[0] <= i_dat[c*DAT_WIDTH +: DAT_WIDTH];
                for (int s = 1; s < D; s++)
                    dat_q[s] <= dat_q[s-1];
            end
        end
        assign o_dat_vld[c]                    = vld_q[D-1];
        assign o_dat[c*DAT_WIDTH +: DAT_WIDTH] = dat_q[D-1];
    end

`ifdef SR_SKEW_INFLIGHT_EN
    logic [CNT_W-1:0] inflight_q;
    logic [CNT_W-1:0] n_in;
    logic [CNT_W-1:0] n_out;
    always_comb begin
        n_in  = '0;
        n_out = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            n_in  = n_in  + CNT_W'(i_dat_vld[i]);
            n_out = n_out + CNT_W'(o_dat_vld[i]);
        end
    end
    // tokens leaving in the same enabled cycle as new ones enter net out in one update
    always_ff @(posedge clk) begin
        if (!rst_n)
            inflight_q <= '0;
        else if (i_en)
            inflight_q <= inflight_q + n_in - n_out;
    end
    assign o_inflight = inflight_q;
`else
    assign o_inflight = '0;
`endif

endmodule
